// File: rtl/sm2_mm_normalizer.sv
// Purpose: turns the SM2 multiplier's redundant digits into a fully reduced 256-bit residue.
// Latency: operand accepted at edge t -> out_valid after edge t+NUM_ELEMENTS+2+n (n = P subtractions); t+NUM_ELEMENTS+1 on overflow error.
// Backpressure: one operation in flight; in_ready only in IDLE, result held stable until out_ready.
module sm2_mm_normalizer #(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int WORD_LEN     = 16,
  parameter int MAX_SUB      = 16,
  parameter logic [WORD_LEN*(NUM_ELEMENTS-1)-1:0] P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [BIT_LEN-1:0]                    in_mm [NUM_ELEMENTS],
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WORD_LEN*(NUM_ELEMENTS-1)-1:0]  out_res,
  output logic                                  out_err
);

  localparam int RES_W = WORD_LEN * (NUM_ELEMENTS - 1);
  localparam int H_W   = BIT_LEN + 1;          // top digit plus incoming carry
  localparam int C_W   = H_W - WORD_LEN;       // inter-digit carry width
  localparam int EXT_W = 4;                    // {H,W} is reduced only while below 2^(RES_W+4)
  localparam int VAL_W = RES_W + EXT_W;
  localparam int K_W   = $clog2(NUM_ELEMENTS);
  localparam int N_W   = $clog2(MAX_SUB + 1);

  typedef enum logic [2:0] {IDLE, CARRY, CHECK, SUB, DONE} state_t;

  state_t              state, state_nxt;
  logic [BIT_LEN-1:0]  dig [NUM_ELEMENTS];
  logic [C_W-1:0]      carry;
  logic [K_W-1:0]      k;
  logic [N_W-1:0]      n;
  logic [RES_W-1:0]    w;
  logic [H_W-1:0]      h;
  logic                err;

  logic [H_W-1:0]      s;
  logic [VAL_W-1:0]    val;
  logic [VAL_W-1:0]    diff;
  logic                ge;
  logic                last_k;
  logic                h_ovf;
  logic                sub_cap;

  // dig[0] is always the digit being absorbed: the digit array shifts down each CARRY cycle
  assign s       = {1'b0, dig[0]} + H_W'(carry);
  assign val     = {h[EXT_W-1:0], w};
  assign ge      = (val >= {{EXT_W{1'b0}}, P});
  assign diff    = val - {{EXT_W{1'b0}}, P};
  assign last_k  = (k == K_W'(NUM_ELEMENTS - 1));
  assign h_ovf   = |h[H_W-1:EXT_W];
  assign sub_cap = (n == N_W'(MAX_SUB));

  // outputs come straight from registers; nothing from in_* reaches out_* combinationally
  assign out_res = w;
  assign out_err = err;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CARRY;
      end
      CARRY: if (last_k) state_nxt = CHECK;
      CHECK: state_nxt = h_ovf ? DONE : SUB;
      SUB:   if (!ge || sub_cap) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: capture, carry ripple (W fills from the top, LSW lands at the bottom), reduction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) dig[i] <= '0;
      carry <= '0;
      k     <= '0;
      n     <= '0;
      w     <= '0;
      h     <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) dig[i] <= in_mm[i];
            carry <= '0;
            k     <= '0;
            n     <= '0;
            w     <= '0;
            h     <= '0;
            err   <= 1'b0;
          end
        end
        CARRY: begin
          for (int i = 0; i < NUM_ELEMENTS - 1; i++) dig[i] <= dig[i+1];
          dig[NUM_ELEMENTS-1] <= '0;
          k <= k + K_W'(1);
          if (last_k) begin
            h <= s;
          end else begin
            w     <= {s[WORD_LEN-1:0], w[RES_W-1:WORD_LEN]};
            carry <= s[H_W-1:WORD_LEN];
          end
        end
        CHECK: begin
          n <= '0;
          if (h_ovf) err <= 1'b1;
        end
        SUB: begin
          if (ge) begin
            if (sub_cap) begin
              err <= 1'b1;
            end else begin
              h <= H_W'(diff[VAL_W-1:RES_W]);
              w <= diff[RES_W-1:0];
              n <= n + N_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm2_mm_normalizer.sv
// Directed bench for sm2_mm_normalizer: residues, latency, backpressure hold, mid-operation reset.
// Latency expectations count edges from the accepting edge to the first sample with out_valid high.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
module tb_sm2_mm_normalizer;

  localparam logic [255:0] P_C =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] R_2_256 =
    256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [16:0]   mm [17];
  logic          out_valid;
  logic          out_ready;
  logic [255:0]  out_res;
  logic          out_err;

  int total = 0;
  int bad   = 0;

  sm2_mm_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mm     (mm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mm();
    for (int i = 0; i < 17; i++) mm[i] = '0;
  endtask

  // arithmetic reference: X = sum mm[i]*2^(16i); error when X >= 2^260, else reduce by P
  task automatic model(output logic [255:0] r, output logic e, output int nsub);
    logic [271:0] x;
    logic [271:0] pp;
    x    = '0;
    pp   = {16'b0, P_C};
    nsub = 0;
    e    = 1'b0;
    for (int i = 0; i < 17; i++) x = x + (272'(mm[i]) << (16 * i));
    if (x[271:260] != 0) begin
      e = 1'b1;
    end else begin
      while (x >= pp) begin
        x = x - pp;
        nsub++;
      end
    end
    r = x[255:0];
  endtask

  // issue the operand in mm, wait (bounded) for the result, check latency/residue/error
  task automatic run_op(input string tag, input logic [255:0] er, input logic ee, input int el);
    int c;
    c = 0;
    chk({tag, ":in_ready"}, 260'(in_ready), 260'(1));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, ":latency"}, 260'(c), 260'(el));
    chk({tag, ":res"}, 260'(out_res), 260'(er));
    chk({tag, ":err"}, 260'(out_err), 260'(ee));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":vld_drop"}, 260'(out_valid), 260'(0));
    chk({tag, ":rdy_back"}, 260'(in_ready), 260'(1));
  endtask

  logic [255:0] mr;
  logic         me;
  int           mn;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_mm();
    repeat (3) @(posedge clk);
    #1;
    chk("rst:in_ready",  260'(in_ready),  260'(1));
    chk("rst:out_valid", 260'(out_valid), 260'(0));
    chk("rst:out_res",   260'(out_res),   260'(0));
    chk("rst:out_err",   260'(out_err),   260'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // all-zero operand
    run_op("zero", 256'h0, 1'b0, 19);
    take("zero");

    // single full digit, already reduced
    clr_mm();
    mm[0] = 17'h1FFFF;
    run_op("d0", 256'h1FFFF, 1'b0, 19);
    take("d0");

    // digits 0..15 all 1FFFF: full carry ripple, two subtractions
    clr_mm();
    for (int i = 0; i < 16; i++) mm[i] = 17'h1FFFF;
    model(mr, me, mn);
    chk("ripple:model_n", 260'(mn), 260'(2));
    run_op("ripple", mr, me, 19 + mn);
    take("ripple");

    // operand equal to P reduces to zero with one subtraction
    clr_mm();
    for (int i = 0; i < 4; i++)  mm[i] = 17'h0FFFF;
    for (int i = 6; i < 14; i++) mm[i] = 17'h0FFFF;
    mm[14] = 17'h0FFFE;
    mm[15] = 17'h0FFFF;
    run_op("eqP", 256'h0, 1'b0, 20);
    take("eqP");

    // X = 2^256 -> 2^256 - P
    clr_mm();
    mm[16] = 17'd1;
    run_op("2pow256", R_2_256, 1'b0, 20);
    take("2pow256");

    // X = 16*2^256 violates the range contract: error, no subtraction
    clr_mm();
    mm[16] = 17'd16;
    run_op("ovf", 256'h0, 1'b1, 18);
    take("ovf");

    // backpressure: hold DONE for 10 cycles while in_valid pulses with other data
    clr_mm();
    mm[0] = 17'h1FFFF;
    run_op("hold", 256'h1FFFF, 1'b0, 19);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      mm[0]    = 17'h00AAA;
      @(posedge clk); #1;
      chk("hold:out_valid", 260'(out_valid), 260'(1));
      chk("hold:out_res",   260'(out_res),   260'(256'h1FFFF));
      chk("hold:in_ready",  260'(in_ready),  260'(0));
    end
    in_valid = 1'b0;
    take("hold");
    // next operand is accepted on the very next edge
    run_op("after_hold", 256'h00AAA, 1'b0, 19);
    take("after_hold");

    // reset while rippling (k = 5)
    clr_mm();
    for (int i = 0; i < 16; i++) mm[i] = 17'h1FFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_carry:in_ready",  260'(in_ready),  260'(1));
    chk("rst_carry:out_valid", 260'(out_valid), 260'(0));
    chk("rst_carry:out_res",   260'(out_res),   260'(0));
    chk("rst_carry:out_err",   260'(out_err),   260'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // reset while subtracting
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    chk("pre_rst_sub:in_ready", 260'(in_ready), 260'(0));
    rst = 1'b1;
    #1;
    chk("rst_sub:in_ready",  260'(in_ready),  260'(1));
    chk("rst_sub:out_valid", 260'(out_valid), 260'(0));
    chk("rst_sub:out_res",   260'(out_res),   260'(0));
    chk("rst_sub:out_err",   260'(out_err),   260'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    // the aborted operation must never produce a result
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk); #1;
        if (out_valid === 1'b1) seen = 1'b1;
      end
      chk("rst_sub:no_output", 260'(seen), 260'(0));
    end

    // operand after the aborts completes correctly
    model(mr, me, mn);
    run_op("post_rst", mr, me, 19 + mn);
    take("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
